// File: rtl/uart_phase_cmd_parser_if.sv
// rtl/uart_phase_cmd_parser_if.sv - UART byte / shift-controller bundle for the phase command parser
interface uart_phase_cmd_parser_if #(
  parameter int NUM_PLLS = 2,
  parameter int CNT_W    = 3,
  parameter int PERIOD_W = 8
);
  localparam int PLL_W = (NUM_PLLS > 1) ? $clog2(NUM_PLLS) : 1;

  logic [7:0]                i_rx_data;
  logic                      i_rx_ready;
  logic                      i_shift_busy;
  logic [NUM_PLLS*CNT_W-1:0] o_phasecounterselect;
  logic [PLL_W-1:0]          o_pll_to_update;
  logic                      o_phaseupdown;
  logic [PERIOD_W-1:0]       o_periods_to_process;
  logic                      o_shift_ready;
  logic                      o_error;
  logic [2:0]                o_error_code;
  logic [2:0]                o_byte_count;

  // UART receiver / shift-controller side
  modport master (
    output i_rx_data, i_rx_ready, i_shift_busy,
    input  o_phasecounterselect, o_pll_to_update, o_phaseupdown,
           o_periods_to_process, o_shift_ready, o_error, o_error_code, o_byte_count
  );

  // Parser side
  modport slave (
    input  i_rx_data, i_rx_ready, i_shift_busy,
    output o_phasecounterselect, o_pll_to_update, o_phaseupdown,
           o_periods_to_process, o_shift_ready, o_error, o_error_code, o_byte_count
  );
endinterface

// File: rtl/uart_phase_cmd_parser.sv
// rtl/uart_phase_cmd_parser.sv - ASCII phase-shift command decoder for N PLLs
module uart_phase_cmd_parser #(
  parameter int                NUM_PLLS     = 2,
  parameter int                GENS_PER_PLL = 4,
  parameter int                CNT_OFFSET   = 2,
  parameter int                CNT_W        = 3,
  parameter logic [CNT_W-1:0]  INIT_COUNTER = 3'b110,
  parameter int                PERIOD_W     = 8,
  parameter int                MAX_DIGITS   = 3
) (
  input logic                    i_clk,
  input logic                    i_rst,
  uart_phase_cmd_parser_if.slave bus
);
  localparam int PLL_W    = (NUM_PLLS > 1) ? $clog2(NUM_PLLS) : 1;
  localparam int NUM_GENS = NUM_PLLS * GENS_PER_PLL;
  localparam int ACC_W    = PERIOD_W + 4;
  localparam int DCNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [ACC_W-1:0] MAX_COUNT = ACC_W'((1 << PERIOD_W) - 1);

  localparam logic [2:0] E_BAD_GEN   = 3'd1;
  localparam logic [2:0] E_BAD_DIR   = 3'd2;
  localparam logic [2:0] E_BAD_DIGIT = 3'd3;
  localparam logic [2:0] E_OVERFLOW  = 3'd4;
  localparam logic [2:0] E_EMPTY     = 3'd5;
  localparam logic [2:0] E_ZERO      = 3'd6;
  localparam logic [2:0] E_BUSY      = 3'd7;

  typedef enum logic [1:0] {S_GEN, S_DIR, S_DIGITS, S_DRAIN} state_t;

  state_t                    state;
  logic                      rx_ready_q;
  logic                      first_q;
  logic [PLL_W-1:0]          pll_q;
  logic [CNT_W-1:0]          sel_q;
  logic                      dir_q;
  logic [PERIOD_W-1:0]       acc;
  logic [DCNT_W-1:0]         dcnt;

  logic [NUM_PLLS*CNT_W-1:0] pcs;
  logic [PLL_W-1:0]          pll_out;
  logic                      dir_out;
  logic [PERIOD_W-1:0]       cnt_out;
  logic                      shift_ready;
  logic                      error;
  logic [2:0]                error_code;
  logic [2:0]                byte_count;

  logic                      accept;
  logic [7:0]                d;
  logic                      is_digit;
  logic                      is_stop;
  logic                      is_gen;
  logic [PLL_W-1:0]          gen_pll;
  logic [CNT_W-1:0]          gen_sel;
  logic [ACC_W-1:0]          next_acc;

  // Byte classification; first_q masks a level that was already high when reset released
  always_comb begin
    accept   = bus.i_rx_ready && !rx_ready_q && !first_q;
    d        = bus.i_rx_data - 8'h30;
    is_digit = (d < 8'd10);
    is_stop  = (bus.i_rx_data == 8'h73);
    is_gen   = is_digit && (d < 8'(NUM_GENS));
    gen_pll  = PLL_W'(d / 8'(GENS_PER_PLL));
    gen_sel  = CNT_W'(d % 8'(GENS_PER_PLL)) + CNT_W'(CNT_OFFSET);
    next_acc = ACC_W'(acc) * ACC_W'(10) + ACC_W'(d[3:0]);
  end

  // Command FSM with registered, atomically committed outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_GEN;
      rx_ready_q  <= 1'b0;
      first_q     <= 1'b1;
      pll_q       <= '0;
      sel_q       <= '0;
      dir_q       <= 1'b0;
      acc         <= '0;
      dcnt        <= '0;
      pcs         <= {NUM_PLLS{INIT_COUNTER}};
      pll_out     <= '0;
      dir_out     <= 1'b1;
      cnt_out     <= '0;
      shift_ready <= 1'b0;
      error       <= 1'b0;
      error_code  <= 3'd0;
      byte_count  <= 3'd0;
    end else begin
      rx_ready_q  <= bus.i_rx_ready;
      first_q     <= 1'b0;
      shift_ready <= 1'b0;
      error       <= 1'b0;
      if (accept) begin
        if (is_stop) begin
          state      <= S_GEN;
          byte_count <= 3'd0;
          case (state)
            S_DIR: begin
              error      <= 1'b1;
              error_code <= E_EMPTY;
            end
            S_DIGITS: begin
              if (dcnt == '0 || acc == '0) begin
                error      <= 1'b1;
                error_code <= E_ZERO;
              end else if (bus.i_shift_busy) begin
                error      <= 1'b1;
                error_code <= E_BUSY;
              end else begin
                for (int p = 0; p < NUM_PLLS; p++) begin
                  if (pll_q == PLL_W'(p)) pcs[p*CNT_W +: CNT_W] <= sel_q;
                end
                pll_out     <= pll_q;
                dir_out     <= dir_q;
                cnt_out     <= acc;
                shift_ready <= 1'b1;
              end
            end
            default: ;
          endcase
        end else begin
          if (byte_count != 3'd7) byte_count <= byte_count + 3'd1;
          case (state)
            S_GEN: begin
              if (is_gen) begin
                pll_q <= gen_pll;
                sel_q <= gen_sel;
                state <= S_DIR;
              end else begin
                error      <= 1'b1;
                error_code <= E_BAD_GEN;
                state      <= S_DRAIN;
              end
            end
            S_DIR: begin
              if (bus.i_rx_data == 8'h30 || bus.i_rx_data == 8'h31) begin
                dir_q <= bus.i_rx_data[0];
                acc   <= '0;
                dcnt  <= '0;
                state <= S_DIGITS;
              end else begin
                error      <= 1'b1;
                error_code <= E_BAD_DIR;
                state      <= S_DRAIN;
              end
            end
            S_DIGITS: begin
              if (!is_digit) begin
                error      <= 1'b1;
                error_code <= E_BAD_DIGIT;
                state      <= S_DRAIN;
              end else if (dcnt == DCNT_W'(MAX_DIGITS) || next_acc > MAX_COUNT) begin
                error      <= 1'b1;
                error_code <= E_OVERFLOW;
                state      <= S_DRAIN;
              end else begin
                acc  <= next_acc[PERIOD_W-1:0];
                dcnt <= dcnt + DCNT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.o_phasecounterselect = pcs;
  assign bus.o_pll_to_update      = pll_out;
  assign bus.o_phaseupdown        = dir_out;
  assign bus.o_periods_to_process = cnt_out;
  assign bus.o_shift_ready        = shift_ready;
  assign bus.o_error              = error;
  assign bus.o_error_code         = error_code;
  assign bus.o_byte_count         = byte_count;
endmodule
